// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state and flag types shared by the alu_seq slice
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic neg;
        logic zero;
        logic overflow;
        logic carry;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - unsigned shift-add multiplier, one partial product per cycle
// The first partial product is folded into the start cycle, so done rises WIDTH-1 cycles after start.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic                 busy;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;

    assign done    = busy && (cnt == LAST);
    assign product = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(1);
            acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier <= b >> 1;
        end else if (done) begin
            busy <= 1'b0;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered handshake ALU; define ALU_MUL_EN to build in the sequential multiplier
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             illegal
);

    alu_state_t       state;
    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    alu_flags_t       alu_flags;
    logic             alu_illegal;
    logic             is_mul;

    assign in_ready = rst_n && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign accept   = in_valid && in_ready;
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = a - b;

`ifdef ALU_MUL_EN
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    alu_flags_t           mul_flags;

    assign is_mul = (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        mul_flags          = '0;
        mul_flags.neg      = mul_product[WIDTH-1];
        mul_flags.zero     = (mul_product[WIDTH-1:0] == '0);
        mul_flags.overflow = (mul_product[2*WIDTH-1:WIDTH] != '0);
    end
`else
    assign is_mul = 1'b0;
`endif

    // Single-cycle datapath; illegal codes fall to default and leave result 0 so zero reads 1.
    always_comb begin
        alu_res     = '0;
        alu_flags   = '0;
        alu_illegal = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res            = sum[WIDTH-1:0];
                alu_flags.carry    = sum[WIDTH];
                alu_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res            = diff;
                alu_flags.carry    = (a < b);
                alu_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: alu_res = a ^ b;
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: alu_res = a << b[SHW-1:0];
            OP_SRL: alu_res = a >> b[SHW-1:0];
            default: alu_illegal = 1'b1;
        endcase
        alu_flags.zero = (alu_res == '0);
        alu_flags.neg  = alu_res[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            neg       <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry     <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept && is_mul) begin
                        state     <= BUSY;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        result    <= alu_res;
                        {neg, zero, overflow, carry} <= alu_flags;
                        illegal   <= alu_illegal;
                    end else if ((state == HOLD) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef ALU_MUL_EN
                BUSY: begin
                    if (mul_done) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        result    <= mul_product[WIDTH-1:0];
                        {neg, zero, overflow, carry} <= mul_flags;
                        illegal   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             neg;
    logic             zero;
    logic             overflow;
    logic             carry;
    logic             illegal;

    int compared   = 0;
    int mismatched = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .neg       (neg),
        .zero      (zero),
        .overflow  (overflow),
        .carry     (carry),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags packed as {illegal, neg, zero, overflow, carry}
    task automatic check_out(input string tag, input logic [WIDTH-1:0] exp_res, input logic [4:0] exp_flags);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".flags"}, {illegal, neg, zero, overflow, carry}, exp_flags);
    endtask

    // Present one op for one cycle; returns on the negedge after the accept edge.
    task automatic issue(input string tag, input logic [3:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        #1;
        check({tag, ".in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        op = 4'b0000; a = '0; b = '0;
    endtask

    initial begin
        int lat;
        int stale;
        int busy_ready;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 4'b0000; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset.in_ready", in_ready, 1'b0);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.regs", {result, illegal, neg, zero, overflow, carry}, '0);
        rst_n = 1'b1;
        #1;
        check("release.in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Back-to-back ops with out_ready held high
        issue("add_ovf", 4'b0001, 32'h7FFF_FFFF, 32'h0000_0001);
        check_out("add_ovf", 32'h8000_0000, 5'b01010);
        issue("sub_eq", 4'b0010, 32'h0000_0005, 32'h0000_0005);
        check_out("sub_eq", 32'h0000_0000, 5'b00100);
        issue("sub_borrow", 4'b0010, 32'h0000_0001, 32'h0000_0002);
        check_out("sub_borrow", 32'hFFFF_FFFF, 5'b01001);
        issue("sub_ovf", 4'b0010, 32'h8000_0000, 32'h0000_0001);
        check_out("sub_ovf", 32'h7FFF_FFFF, 5'b00010);
        issue("add_carry", 4'b0001, 32'hFFFF_FFFF, 32'h0000_0001);
        check_out("add_carry", 32'h0000_0000, 5'b00101);
        issue("slt", 4'b0101, 32'hFFFF_FFFF, 32'h0000_0001);
        check_out("slt", 32'h0000_0001, 5'b00000);
        issue("slt_false", 4'b0101, 32'h0000_0001, 32'hFFFF_FFFF);
        check_out("slt_false", 32'h0000_0000, 5'b00100);
        issue("sll", 4'b0110, 32'h0000_0001, 32'h0000_0025);
        check_out("sll", 32'h0000_0020, 5'b00000);
        issue("srl", 4'b0111, 32'h8000_0000, 32'h0000_001F);
        check_out("srl", 32'h0000_0001, 5'b00000);
        issue("xor", 4'b0011, 32'h0000_F0F0, 32'h0000_FF00);
        check_out("xor", 32'h0000_0FF0, 5'b00000);
        issue("and", 4'b0100, 32'hF000_F0F0, 32'h8000_FF00);
        check_out("and", 32'h8000_F000, 5'b01000);
        issue("or", 4'b1000, 32'h0000_F0F0, 32'h0000_FF00);
        check_out("or", 32'h0000_FFF0, 5'b00000);
        issue("illegal_f", 4'b1111, 32'h1234_5678, 32'h1234_5678);
        check_out("illegal_f", 32'h0000_0000, 5'b10100);
        issue("illegal_0", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
        check_out("illegal_0", 32'h0000_0000, 5'b10100);
        @(negedge clk);
        check("drain.out_valid", out_valid, 1'b0);

        // Backpressure: first result held, second waits for the drain cycle
        out_ready = 1'b0;
        issue("bp_first", 4'b0001, 32'h0000_0001, 32'h0000_0002);
        check_out("bp_first", 32'h0000_0003, 5'b00000);
        op = 4'b0001; a = 32'h0000_000A; b = 32'h0000_0014; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp.in_ready_low", in_ready, 1'b0);
            @(negedge clk);
            check_out("bp_hold", 32'h0000_0003, 5'b00000);
        end
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_drain", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("bp_second", 32'h0000_001E, 5'b00000);
        @(negedge clk);
        check("bp.drained", out_valid, 1'b0);

`ifdef ALU_MUL_EN
        issue("mul_ovf", 4'b1001, 32'h0001_0000, 32'h0001_0000);
        lat = 1; busy_ready = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ready++;
            @(negedge clk);
            lat++;
        end
        check("mul.latency", lat, 33);
        check("mul.in_ready_busy", busy_ready, 0);
        check_out("mul_ovf", 32'h0000_0000, 5'b00110);
        issue("mul_small", 4'b1001, 32'h0000_1234, 32'h0000_0010);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("mul_small.latency", lat, 33);
        check_out("mul_small", 32'h0001_2340, 5'b00000);
        issue("mul_max", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("mul_max.latency", lat, 33);
        check_out("mul_max", 32'h0000_0001, 5'b00010);
        @(negedge clk);

        // Reset ten cycles into a multiply
        issue("mul_abort", 4'b1001, 32'h0000_0003, 32'h0000_0005);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.in_ready_rst", in_ready, 1'b0);
        @(negedge clk);
        check("abort.out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        check("abort.in_ready_rel", in_ready, 1'b1);
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("abort.no_stale", stale, 0);
`else
        issue("mul_disabled", 4'b1001, 32'h0000_0003, 32'h0000_0005);
        check_out("mul_disabled", 32'h0000_0000, 5'b10100);
        @(negedge clk);
`endif

        // Reset while a result is held under backpressure
        out_ready = 1'b0;
        issue("rst_hold", 4'b0001, 32'h0000_0004, 32'h0000_0004);
        check_out("rst_hold", 32'h0000_0008, 5'b00000);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_hold.out_valid", out_valid, 1'b0);
        check("rst_hold.result", result, 32'h0000_0000);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_hold.no_stale", stale, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU with a valid/ready handshake on both sides. It is the next generation of the datapath ALU: width is generic, the opcode set is larger (XOR, SLT, shifts), and all four flags are computed correctly for every op. An optional multi-cycle unsigned multiplier sits behind the same handshake. It sits between operand fetch and writeback in the execute stage.

## Interface
- `WIDTH`, 32: operand/result width; power of two, 8..64.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `in_valid` in 1: operands and op presented.
- `in_ready` out 1: block accepts the operation this cycle.
- `op` in 4: opcode (see Operation).
- `a`, `b` in WIDTH: operands.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer takes the result this cycle.
- `result` out WIDTH: result.
- `neg`, `zero`, `overflow`, `carry` out 1 each: flags.
- `illegal` out 1: accepted op was undefined.

## Operation
- Opcodes: 0001 ADD, 0010 SUB, 0011 XOR, 0100 AND, 0101 SLT (signed, result 1/0), 0110 SLL, 0111 SRL (logical), 1000 OR, 1001 MUL. All other codes are illegal.
- Shifts use `b[SHW-1:0]` and ignore the upper bits of `b`.
- `zero` = (result == 0). `neg` = result[WIDTH-1]. This applies to every op.
- ADD: `carry` = carry-out. `overflow` = the operands have the same sign and the result sign differs.
- SUB: `carry` = borrow (a < b unsigned). `overflow` = the operands have different signs and the result sign differs from `a`.
- MUL: unsigned. `result` = low WIDTH bits. `overflow` = the high half is nonzero. `carry` = 0.
- For all other ops, `overflow` = `carry` = 0.
- Illegal op:
  - `result` = 0, `illegal` = 1, `zero` = 1, and all other flags = 0.
  - It completes with single-cycle latency.
  - MUL with `ALU_MUL_EN` undefined is also treated as illegal.
- FSM states:
  - IDLE: no result held.
  - BUSY: MUL in progress.
  - HOLD: result held until drained.
- FSM transitions:
  - IDLE/HOLD, accept of a non-MUL op → HOLD.
  - IDLE/HOLD, accept of MUL → BUSY.
  - BUSY, counter reaches WIDTH → HOLD.
  - HOLD, `out_ready` with no new accept → IDLE.
- `in_ready` = (state == IDLE) or (state == HOLD and `out_ready`). `in_ready` is 0 throughout BUSY.
- Accept = `in_valid` & `in_ready`. `a`, `b` and `op` are captured only on accept.
- Output registers change only on completion. They remain stable while `out_valid` = 1 and `out_ready` = 0.
- Reset:
  - State → IDLE, and any MUL in progress is aborted.
  - `out_valid`, `result`, all flags and `illegal` → 0.
  - `in_ready` reads 0 during the reset cycle.

## Timing
- Single-cycle ops: `out_valid` rises on the first edge after the accept edge (latency 1).
- Back-to-back throughput is 1 op/cycle while `out_ready` = 1.
- MUL uses a shift-add scheme with one partial product per cycle. `out_valid` rises WIDTH+1 cycles after accept.
- Backpressure: a result in HOLD with `out_ready` = 0 blocks new accepts. No result is ever dropped or overwritten.
- Simultaneous drain and accept in HOLD: the new result replaces the old one on the same edge, so `out_valid` stays 1.
- `rst_n` low mid-MUL: the partial product is discarded and no `out_valid` is produced.

## Configuration
- `ALU_MUL_EN` defined: the multiplier sub-module and the BUSY state are compiled in.
- `ALU_MUL_EN` undefined:
  - No multiplier logic and no BUSY state.
  - Op 1001 is illegal.
  - `in_ready` depends only on IDLE/HOLD.

## Structure
- `alu_pkg` holds:
  - the opcode localparams (`OP_ADD` … `OP_MUL`);
  - the state enum `alu_state_t` (IDLE, BUSY, HOLD);
  - the flags struct `alu_flags_t` (neg, zero, overflow, carry).
- One sub-module, `alu_mul_seq`:
  - interface: start, a, b, done, product[2*WIDTH-1:0];
  - WIDTH-cycle shift-add with an internal counter;
  - instantiated only under `ALU_MUL_EN`.
- The single-cycle datapath and flag logic stay in `alu_seq`.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, neg = 1, overflow = 1, carry = 0, zero = 0, `out_valid` 1 cycle after accept.
- SUB 0x00000005 − 0x00000005 → result 0, zero = 1, carry = 0. SUB 0x00000001 − 0x00000002 → 0xFFFFFFFF, carry = 1, neg = 1, overflow = 0.
- SLT a = 0xFFFFFFFF, b = 0x00000001 → result 1. SLL a = 0x00000001, b = 0x00000025 → result 0x00000020 (shift by 5).
- MUL 0x00010000 × 0x00010000 (`ALU_MUL_EN`) → result 0, overflow = 1, zero = 1. `out_valid` arrives exactly 33 cycles after accept, with `in_ready` = 0 in between.
- Backpressure: two ADDs issued with `out_ready` held low for 3 cycles → first result held stable, second not accepted until the drain cycle, then delivered the next cycle. Op 1111 → illegal = 1, result 0.
- Assert `rst_n` low 10 cycles into a MUL → next cycle `out_valid` = 0, `in_ready` = 1 after release, and no stale result appears.
